// File: rtl/overlay_motion_ctrl.sv
// ---------------------------------------------------------------------------
// overlay_motion_ctrl
//   Frame-rate sequencer for the text banner overlay. Once per frame (rising
//   edge of vsync) it may move the banner origin one cell in bounce mode,
//   rotate the displayed banner on every wall bounce, and blink the banner
//   after a corner hit. enable=0 on a frame event parks everything (PAUSE).
//
//   Ports
//     clk        in   pixel clock
//     rst_n      in   asynchronous active-low reset
//     vsync      in   active-high vertical sync level, synchronous to clk
//     enable     in   1 = animate, 0 = pause (sampled on frame events only)
//     origin_x   out  banner left edge in cells, 0..GRID_W-BOX_W
//     origin_y   out  banner top edge in cells, 0..GRID_H-BOX_H
//     banner_sel out  active banner index, 0..NUM_BANNERS-1
//     overlay_en out  banner visibility gate
//     hit_count  out  corner-hit counter, wraps 255->0
// ---------------------------------------------------------------------------
module overlay_motion_ctrl #(
  parameter int GRID_W       = 80,
  parameter int GRID_H       = 60,
  parameter int BOX_W        = 23,
  parameter int BOX_H        = 9,
  parameter int X0           = 30,
  parameter int Y0           = 24,
  parameter int STEP_FRAMES  = 4,
  parameter int BLINK_FRAMES = 32,
  parameter int NUM_BANNERS  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       enable,
  output logic [6:0] origin_x,
  output logic [5:0] origin_y,
  output logic [1:0] banner_sel,
  output logic       overlay_en,
  output logic [7:0] hit_count
);

  localparam int XMAX = GRID_W - BOX_W;
  localparam int YMAX = GRID_H - BOX_H;
  localparam int SW   = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam int BW   = $clog2(BLINK_FRAMES);

  typedef enum logic [1:0] {S_RUN, S_BLINK, S_PAUSE} state_t;

  state_t          state, state_n;
  logic            vsync_q;
  logic [SW-1:0]   step_cnt, step_n;
  logic [BW-1:0]   blink_cnt, blink_n;
  logic            dx_neg, dx_neg_n;   // 1 = moving left
  logic            dy_neg, dy_neg_n;   // 1 = moving up
  logic [6:0]      x_n;
  logic [5:0]      y_n;
  logic [1:0]      sel_n;
  logic            en_n;
  logic [7:0]      hit_n;

  logic            frame_evt;
  logic            step_last, blink_last;
  logic            x_edge, y_edge, x_neg_new, y_neg_new;
  logic [6:0]      x_step;
  logic [5:0]      y_step;
  logic [1:0]      sel_inc;

  assign frame_evt  = vsync & ~vsync_q;
  assign step_last  = (step_cnt == SW'(STEP_FRAMES - 1));
  assign blink_last = (blink_cnt == BW'(BLINK_FRAMES - 1));

  // Sitting on the wall we are heading into means this step bounces: the
  // direction flips first, then the one-cell move uses the new direction,
  // so the origin can never leave 0..MAX.
  assign x_edge    = dx_neg ? (origin_x == 7'd0) : (origin_x == 7'(XMAX));
  assign y_edge    = dy_neg ? (origin_y == 6'd0) : (origin_y == 6'(YMAX));
  assign x_neg_new = dx_neg ^ x_edge;
  assign y_neg_new = dy_neg ^ y_edge;
  assign x_step    = x_neg_new ? origin_x - 7'd1 : origin_x + 7'd1;
  assign y_step    = y_neg_new ? origin_y - 6'd1 : origin_y + 6'd1;
  assign sel_inc   = (banner_sel == 2'(NUM_BANNERS - 1)) ? 2'd0 : banner_sel + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RUN;
      vsync_q    <= 1'b0;
      step_cnt   <= '0;
      blink_cnt  <= '0;
      dx_neg     <= 1'b0;
      dy_neg     <= 1'b0;
      origin_x   <= 7'(X0);
      origin_y   <= 6'(Y0);
      banner_sel <= 2'd0;
      overlay_en <= 1'b1;
      hit_count  <= 8'd0;
    end else begin
      state      <= state_n;
      vsync_q    <= vsync;
      step_cnt   <= step_n;
      blink_cnt  <= blink_n;
      dx_neg     <= dx_neg_n;
      dy_neg     <= dy_neg_n;
      origin_x   <= x_n;
      origin_y   <= y_n;
      banner_sel <= sel_n;
      overlay_en <= en_n;
      hit_count  <= hit_n;
    end
  end

  always_comb begin
    state_n  = state;
    step_n   = step_cnt;
    blink_n  = blink_cnt;
    dx_neg_n = dx_neg;
    dy_neg_n = dy_neg;
    x_n      = origin_x;
    y_n      = origin_y;
    sel_n    = banner_sel;
    en_n     = overlay_en;
    hit_n    = hit_count;
    if (frame_evt) begin
      if (!enable) begin
        // Pause wins over everything, including an in-flight blink.
        state_n = S_PAUSE;
        en_n    = 1'b1;
      end else begin
        case (state)
          S_RUN: begin
            if (step_last) begin
              step_n   = '0;
              dx_neg_n = x_neg_new;
              dy_neg_n = y_neg_new;
              x_n      = x_step;
              y_n      = y_step;
              if (x_edge || y_edge) sel_n = sel_inc;
              if (x_edge && y_edge) begin
                hit_n   = hit_count + 8'd1;
                blink_n = '0;
                state_n = S_BLINK;
              end
            end else begin
              step_n = step_cnt + 1'b1;
            end
          end
          S_BLINK: begin
            if (blink_last) begin
              en_n    = 1'b1;
              step_n  = '0;
              state_n = S_RUN;
            end else begin
              // Blink frame k shows ~k[2]: four on, four off, starting on.
              en_n    = ~blink_cnt[2];
              blink_n = blink_cnt + 1'b1;
            end
          end
          S_PAUSE: state_n = S_RUN;  // resume frame consumes no step
          default: state_n = S_RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_overlay_motion_ctrl.sv
module tb_overlay_motion_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       vsync;
  logic       enable;
  logic [6:0] origin_x;
  logic [5:0] origin_y;
  logic [1:0] banner_sel;
  logic       overlay_en;
  logic [7:0] hit_count;

  int n_tests = 0;
  int n_fail  = 0;

  overlay_motion_ctrl dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .enable(enable),
    .origin_x(origin_x), .origin_y(origin_y), .banner_sel(banner_sel),
    .overlay_en(overlay_en), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // mode: 0 run, 1 blink, 2 pause
  int m_x, m_y, m_dx, m_dy, m_sel, m_en, m_hit, m_mode, m_step, m_blink;

  task automatic m_reset();
    m_x = 30; m_y = 24; m_dx = 1; m_dy = 1; m_sel = 0; m_en = 1; m_hit = 0;
    m_mode = 0; m_step = 0; m_blink = 0;
  endtask

  task automatic m_frame(input bit en);
    bit bx, by;
    if (!en) begin m_mode = 2; m_en = 1; return; end
    if (m_mode == 2) begin m_mode = 0; return; end
    if (m_mode == 1) begin
      if (m_blink == 31) begin m_en = 1; m_step = 0; m_mode = 0; end
      else begin m_en = ((m_blink % 8) < 4) ? 1 : 0; m_blink++; end
      return;
    end
    if (m_step < 3) begin m_step++; return; end
    m_step = 0;
    bx = (m_x + m_dx < 0) || (m_x + m_dx > 57);
    by = (m_y + m_dy < 0) || (m_y + m_dy > 51);
    if (bx) m_dx = -m_dx;
    if (by) m_dy = -m_dy;
    m_x += m_dx;
    m_y += m_dy;
    if (bx || by) m_sel = (m_sel + 1) % 4;
    if (bx && by) begin m_hit = (m_hit + 1) % 256; m_blink = 0; m_mode = 1; end
  endtask

  function automatic logic [23:0] m_pack();
    return {7'(m_x), 6'(m_y), 2'(m_sel), 1'(m_en), 8'(m_hit)};
  endfunction

  function automatic logic [23:0] dut_pack();
    return {origin_x, origin_y, banner_sel, overlay_en, hit_count};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; vsync = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    @(negedge clk);
  endtask

  // One frame: vsync high for 'hold' cycles, then low for 'gap'+1 cycles.
  task automatic pulse(input bit en, input int hold, input int gap);
    enable = en;
    vsync  = 1'b1;
    repeat (hold) @(negedge clk);
    vsync  = 1'b0;
    repeat (gap + 1) @(negedge clk);
    m_frame(en);
  endtask

  task automatic run_frames(input int n, input string tag);
    bit bad = 0;
    logic [23:0] a = '0, e = '0;
    for (int i = 0; i < n; i++) begin
      pulse(1'b1, 1, 1);
      if (!bad && dut_pack() !== m_pack()) begin bad = 1; a = dut_pack(); e = m_pack(); end
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, a, e);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_tests++;
    if (dut_pack() !== {7'd30, 6'd24, 2'd0, 1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", dut_pack(), {7'd30, 6'd24, 2'd0, 1'b1, 8'd0});
    end
  endtask

  task automatic test_first_step();
    bit en_ok = 1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pulse(1'b1, 1, 1);
      if (overlay_en !== 1'b1) en_ok = 0;
    end
    n_tests++;
    if ({origin_x, origin_y, banner_sel} !== {7'd31, 6'd25, 2'd0} || !en_ok) begin
      n_fail++;
      $display("FAIL first_step: got x=%0d y=%0d sel=%0d en_ok=%0d expected 31 25 0 1",
               origin_x, origin_y, banner_sel, en_ok);
    end
    n_tests++;
    if (dut_pack() !== m_pack()) begin
      n_fail++;
      $display("FAIL first_step_model: got %h expected %h", dut_pack(), m_pack());
    end
  endtask

  task automatic test_corner_and_blink();
    logic [31:0] pat = '0;
    do_reset();
    run_frames(108, "approach_corner");
    n_tests++;
    if ({origin_x, origin_y} !== {7'd57, 6'd51}) begin
      n_fail++;
      $display("FAIL step27: got (%0d,%0d) expected (57,51)", origin_x, origin_y);
    end
    run_frames(4, "corner_step");
    n_tests++;
    if ({origin_x, origin_y, banner_sel, hit_count} !== {7'd56, 6'd50, 2'd1, 8'd1}) begin
      n_fail++;
      $display("FAIL corner_hit: got (%0d,%0d) sel=%0d hit=%0d expected (56,50) sel=1 hit=1",
               origin_x, origin_y, banner_sel, hit_count);
    end
    for (int k = 0; k < 32; k++) begin
      pulse(1'b1, 1, 1);
      pat[31-k] = overlay_en;
      n_tests++;
      if ({origin_x, origin_y} !== {7'd56, 6'd50}) begin
        n_fail++;
        $display("FAIL blink_frozen[%0d]: got (%0d,%0d) expected (56,50)", k, origin_x, origin_y);
      end
    end
    n_tests++;
    if (pat !== 32'hF0F0_F0F1) begin
      n_fail++;
      $display("FAIL blink_pattern: got %h expected f0f0f0f1", pat);
    end
    run_frames(4, "post_blink");
    n_tests++;
    if ({origin_x, origin_y, overlay_en} !== {7'd55, 6'd49, 1'b1}) begin
      n_fail++;
      $display("FAIL post_blink_move: got (%0d,%0d) en=%0d expected (55,49) en=1",
               origin_x, origin_y, overlay_en);
    end
  endtask

  task automatic test_pause();
    do_reset();
    run_frames(10, "pre_pause");
    for (int i = 0; i < 3; i++) pulse(1'b0, 1, 1);
    n_tests++;
    if ({origin_x, origin_y, overlay_en} !== {7'd32, 6'd26, 1'b1}) begin
      n_fail++;
      $display("FAIL pause_frozen: got (%0d,%0d) en=%0d expected (32,26) en=1",
               origin_x, origin_y, overlay_en);
    end
    pulse(1'b1, 1, 1);   // resume frame
    pulse(1'b1, 1, 1);   // step_cnt 2 -> 3
    n_tests++;
    if ({origin_x, origin_y} !== {7'd32, 6'd26}) begin
      n_fail++;
      $display("FAIL pause_resume_early: got (%0d,%0d) expected (32,26)", origin_x, origin_y);
    end
    pulse(1'b1, 1, 1);
    n_tests++;
    if ({origin_x, origin_y} !== {7'd33, 6'd27} || dut_pack() !== m_pack()) begin
      n_fail++;
      $display("FAIL pause_resume_move: got %h expected %h (x=33 y=27)", dut_pack(), m_pack());
    end
  endtask

  task automatic test_async_reset_mid_blink();
    do_reset();
    run_frames(112, "to_blink");
    run_frames(5, "blink5");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if (dut_pack() !== {7'd30, 6'd24, 2'd0, 1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", dut_pack(), {7'd30, 6'd24, 2'd0, 1'b1, 8'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    @(negedge clk);
    run_frames(4, "after_async_reset");
  endtask

  task automatic test_vsync_hold();
    bit moved = 0;
    do_reset();
    run_frames(3, "hold_pre");
    enable = 1'b1;
    vsync  = 1'b1;
    @(negedge clk);
    m_frame(1'b1);
    n_tests++;
    if ({origin_x, origin_y} !== {7'd31, 6'd25}) begin
      n_fail++;
      $display("FAIL hold_first_edge: got (%0d,%0d) expected (31,25)", origin_x, origin_y);
    end
    repeat (999) begin
      @(negedge clk);
      if (dut_pack() !== m_pack()) moved = 1;
    end
    n_tests++;
    if (moved) begin
      n_fail++;
      $display("FAIL hold_stable: got %h expected %h", dut_pack(), m_pack());
    end
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    pulse(1'b1, 1, 1);
    run_frames(3, "hold_post");
    n_tests++;
    if ({origin_x, origin_y} !== {7'd32, 6'd26}) begin
      n_fail++;
      $display("FAIL hold_frame_count: got (%0d,%0d) expected (32,26)", origin_x, origin_y);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    logic [23:0] a = '0, e = '0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      pulse(($urandom_range(0, 15) != 0), $urandom_range(1, 4), $urandom_range(0, 3));
      if (dut_pack() !== m_pack()) begin
        if (bad == 0) begin a = dut_pack(); e = m_pack(); end
        bad++;
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL random_frames: %0d mismatching frames, first got %h expected %h", bad, a, e);
    end
    n_tests++;
    if (m_hit == 0) begin
      n_fail++;
      $display("FAIL random_coverage: got hit_count %0d expected nonzero", m_hit);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    vsync  = 1'b0;
    enable = 1'b1;
    m_reset();
    test_reset();
    test_first_step();
    test_corner_and_blink();
    test_pause();
    test_async_reset_mid_blink();
    test_vsync_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
